// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM state encoding and jump-condition codes.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [1:0] CondAlways  = 2'b00;
    localparam logic [1:0] CondZero    = 2'b01;
    localparam logic [1:0] CondNotZero = 2'b10;
    localparam logic [1:0] CondSc      = 2'b11;

    function automatic logic cond_true(input logic [1:0] c, input logic zero, input logic sc);
        logic r;
        case (c)
            CondAlways:  r = 1'b1;
            CondZero:    r = zero;
            CondNotZero: r = ~zero;
            default:     r = sc;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jump_lut.sv
// Jump-target table: one synchronous write port, one asynchronous read port, never reset.
module jump_lut #(
    parameter int unsigned D  = 12,
    parameter int unsigned LW = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [LW-1:0] waddr_i,
    input  logic [D-1:0]  wdata_i,
    input  logic [LW-1:0] raddr_i,
    output logic [D-1:0]  rdata_o
);

    logic [D-1:0] mem_q [2**LW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-write contents during a same-cycle write.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_seq.sv
// Program-counter sequencer: IDLE/RUN/DONE control with LUT-targeted conditional jumps,
// registered ALU flags and a saturating run-cycle counter.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int unsigned D        = 12,
    parameter int unsigned LW       = 5,
    parameter int unsigned END_ADDR = 128,
    parameter int unsigned CW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          stall,
    input  logic          reljump_en,
    input  logic          absjump_en,
    input  logic [1:0]    cond,
    input  logic [LW-1:0] how_high,
    input  logic          halt_i,
    input  logic          zero_i,
    input  logic          pari_i,
    input  logic          sc_i,
    input  logic          flag_en,
    input  logic          sc_clr,
    input  logic          sc_en,
    input  logic          lut_we,
    input  logic [LW-1:0] lut_waddr,
    input  logic [D-1:0]  lut_wdata,
    output logic [D-1:0]  prog_ctr,
    output logic          zeroQ,
    output logic          pariQ,
    output logic          sc_q,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cycles
);

    localparam logic [D-1:0] EndPc = D'(END_ADDR);

    state_e        state_q, state_d;
    logic [D-1:0]  pc_q, pc_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          zero_q, zero_d, pari_q, pari_d, sc_flag_q, sc_flag_d;
    logic [D-1:0]  lut_rdata;
    logic          jump_take;

    jump_lut #(
        .D  (D),
        .LW (LW)
    ) u_jump_lut (
        .clk_i   (clk),
        .we_i    (lut_we),
        .waddr_i (lut_waddr),
        .wdata_i (lut_wdata),
        .raddr_i (how_high),
        .rdata_o (lut_rdata)
    );

    assign jump_take = (reljump_en | absjump_en) & cond_true(cond, zero_q, sc_flag_q);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cycles_d  = cycles_q;
        zero_d    = zero_q;
        pari_d    = pari_q;
        sc_flag_d = sc_flag_q;
        unique case (state_q)
            StIdle: begin
                pc_d = '0;
                if (req) begin
                    state_d  = StRun;
                    cycles_d = '0;
                end
            end
            StRun: begin
                // Stalled cycles still count as run cycles.
                if (cycles_q != '1) begin
                    cycles_d = cycles_q + 1'b1;
                end
                if (!stall) begin
                    if (flag_en) begin
                        zero_d = zero_i;
                        pari_d = pari_i;
                    end
                    if (sc_clr) begin
                        sc_flag_d = 1'b0;
                    end else if (sc_en) begin
                        sc_flag_d = sc_i;
                    end
                    if (halt_i || pc_q == EndPc) begin
                        state_d = StDone;
                    end else if (jump_take) begin
                        pc_d = absjump_en ? lut_rdata : pc_q + lut_rdata;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (!req) begin
                    state_d = StIdle;
                    pc_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            cycles_q  <= '0;
            zero_q    <= 1'b0;
            pari_q    <= 1'b0;
            sc_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cycles_q  <= cycles_d;
            zero_q    <= zero_d;
            pari_q    <= pari_d;
            sc_flag_q <= sc_flag_d;
        end
    end

    assign prog_ctr = pc_q;
    assign cycles   = cycles_q;
    assign zeroQ    = zero_q;
    assign pariQ    = pari_q;
    assign sc_q     = sc_flag_q;
    assign busy     = (state_q == StRun);
    assign done     = (state_q == StDone);

endmodule
